control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Moore/Mealy FSM that drives every control wire of the multicycle MIPS-subset datapath: mux selects, register load enables, memory strobes, ALU opcode.
- Consumes the IR opcode/funct fields and the ALU flags; produces the control bus the datapath's muxes, registers, memory and ula32 consume.
- Handles the exception sequence: save EPC, read the handler byte, jump.

Parameters:
- SP_INIT, 227, value written to $29 in the post-reset cycle.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0] (Immediate[5:0]).
- alu_overflow  in  1  ula32 overflow flag.
- alu_eq  in  1  ula32 equal flag.
- PcWrite, Load_AB, ALUOut_Load, EPCwrite, MemWrite, MemRead, IRWrite, RegWrite  out  1 each  load/strobe enables.
- IorD  out  3  0=PC, 1=ExCause, 2=ALUOut, 3=ALU_result.
- ExcSel  out  2  ExCause address: 0=253 (bad opcode), 1=254 (overflow).
- WR_REG  out  3  0=rt, 1=rd, 2=31, 3=29.
- WD_REG  out  4  0=ALUOut, 1=LoadAux, 2=PC, 3=SP_INIT.
- ALUSrcA  out  3  0=PC, 1=A, 2=zero.
- ALUSrcB  out  3  0=B, 1=4, 2=Ex_16or8to32, 3=Shift_left2.
- PcSource  out  3  0=ALU_result, 1=ALUOut, 2=jump target, 3=EPC.
- ALUOp  out  3  ula32 code: 000 passA, 001 add, 010 sub, 011 and, 111 compare.
- SingExCtrl  out  1  0=sign-extend imm16, 1=zero-extend Mem_Out[7:0].
- LoadCtrl, StoreCtrl  out  2 each  fixed 0 (word).
- state_dbg  out  5  current state encoding.

Behaviour:
- Reset and defaults:
  - reset asserts asynchronously; state goes to RST and all outputs drive 0 while reset is high.
  - Any signal not listed for a state is 0.
- RST (first cycle after reset release): WR_REG=3, WD_REG=3, RegWrite=1, so $29<=SP_INIT. Next state is F0.
- Fetch: memory read latency is 2 cycles.
  - F0: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=1, ALUOp=001.
  - F1: same as F0.
  - F2: IRWrite=1, PcSource=0, PcWrite=1 (PC<=PC+4), ALU held as in F0.
- DEC: Load_AB=1, ALUSrcA=0, ALUSrcB=3, ALUOp=001, ALUOut_Load=1 (branch target). Dispatch on opcode:
  - 0x00 goes to R-type by funct: 0x20 add, 0x22 sub, 0x24 and, 0x08 jr, 0x13 rte.
  - 0x08 addi, 0x09 addiu, 0x23 lw, 0x2B sw, 0x04 beq, 0x05 bne, 0x02 j, 0x03 jal.
  - Anything else goes to EXC0 with ExcSel=0.
- R-type:
  - REX: ALUSrcA=1, ALUSrcB=0, ALUOp = 001/010/011, ALUOut_Load=1. If alu_overflow=1 for add/sub at the edge, go to EXC0 (ExcSel=1); otherwise go to RWB.
  - RWB: WR_REG=1, WD_REG=0, RegWrite=1, then F0.
- Immediate arithmetic:
  - IEX: ALUSrcA=1, ALUSrcB=2, ALUOp=001, ALUOut_Load=1. Overflow is checked for addi only (to EXC0, ExcSel=1); addiu ignores it.
  - IWB: WR_REG=0, WD_REG=0, RegWrite=1.
- Loads and stores:
  - MADR: same datapath controls as IEX, no overflow check. Goes to LR0 for lw, SWR for sw.
  - LR0, LR1: IorD=2, MemRead=1.
  - LWB: WR_REG=0, WD_REG=1, RegWrite=1.
  - SWR: IorD=2, MemWrite=1.
- Branches (BR): ALUSrcA=1, ALUSrcB=0, ALUOp=111, PcSource=1.
  - PcWrite is Mealy: high when (beq & alu_eq) or (bne & !alu_eq).
  - Next state is F0.
- Jumps:
  - JMP: PcSource=2, PcWrite=1.
  - JAL: WR_REG=2, WD_REG=2, RegWrite=1, then JMP. The PC already holds PC+4, which is the link value.
  - JR: ALUSrcA=1, ALUOp=000, PcSource=0, PcWrite=1.
  - RTE: PcSource=3, PcWrite=1.
  - All four end at F0.
- Exceptions:
  - EXC0: ExcSel held, IorD=1, MemRead=1, ALUSrcA=0, ALUSrcB=1, ALUOp=010, EPCwrite=1 (EPC<=PC-4).
  - EXC1: IorD=1, MemRead=1, ExcSel held.
  - EXC2: SingExCtrl=1, ALUSrcA=2, ALUSrcB=2, ALUOp=001, PcSource=0, PcWrite=1, so PC<=zext(Mem[ExcSel addr][7:0]). Then F0.
  - ExcSel is registered on entry to EXC0 and held through EXC2.
- Register file protection: overflow never produces RegWrite for the faulting instruction. The only RegWrite states are RST, RWB, IWB, LWB and JAL.
- Reset mid-instruction: abort immediately to RST. A partially completed store or write is not replayed.
- Cycle counts:
  - R/addi: 6. lw: 8. sw: 6. branch/j/jr/rte: 5. jal: 6.
  - Exception: 3 cycles beyond the detecting state.

Decomposition:
- Package control_pkg holds:
  - state enum, 5-bit.
  - opcode and funct constants.
  - ALUOp codes.
  - mux-select constants for IorD, WR_REG, WD_REG, ALUSrcA, ALUSrcB, PcSource, ExcSel.
- No sub-module: a single next-state block plus one output decode block.

Test Plan:
- Reset release, then observe RST and F0. RegWrite=1, WR_REG=3, WD_REG=3 in RST; F0 shows MemRead=1, IorD=0.
- opcode=0, funct=0x20, alu_overflow=0. Sequence F0,F1,F2,DEC,REX,RWB, with RegWrite=1 and WR_REG=1 only in RWB.
- Same add with alu_overflow=1 in REX. Goes REX to EXC0 with ExcSel=1 and EPCwrite=1, then EXC1, then EXC2 with PcWrite=1, SingExCtrl=1. RegWrite never asserts.
- opcode=0x04 with alu_eq=1 gives PcWrite=1, PcSource=1 in BR. opcode=0x05 with alu_eq=1 gives PcWrite=0.
- opcode=0x3F: DEC goes to EXC0 with ExcSel=0, IorD=1. opcode=0x03 gives JAL (WR_REG=2, WD_REG=2, RegWrite=1), then JMP (PcSource=2).
- reset pulsed during LR1. Outputs go to 0 in the same cycle, state_dbg=RST, and the FSM restarts at F0.

Source files
------------

// File: rtl/control_pkg.sv
// Shared definitions for the multicycle MIPS-subset control unit: state encoding,
// instruction field constants, ALU codes, datapath mux selects and the control bus.
package control_pkg;

    // Constant the datapath drives onto the register write port when WD_REG selects it.
    localparam int unsigned SP_INIT = 227;

    typedef enum logic [4:0] {
        S_RST  = 5'd0,
        S_F0   = 5'd1,
        S_F1   = 5'd2,
        S_F2   = 5'd3,
        S_DEC  = 5'd4,
        S_REX  = 5'd5,
        S_RWB  = 5'd6,
        S_IEX  = 5'd7,
        S_IWB  = 5'd8,
        S_MADR = 5'd9,
        S_LR0  = 5'd10,
        S_LR1  = 5'd11,
        S_LWB  = 5'd12,
        S_SWR  = 5'd13,
        S_BR   = 5'd14,
        S_JMP  = 5'd15,
        S_JAL  = 5'd16,
        S_JR   = 5'd17,
        S_RTE  = 5'd18,
        S_EXC0 = 5'd19,
        S_EXC1 = 5'd20,
        S_EXC2 = 5'd21
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_RTE = 6'h13;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;

    localparam logic [2:0] ALU_PASSA = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b001;
    localparam logic [2:0] ALU_SUB   = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_CMP   = 3'b111;

    localparam logic [2:0] IORD_PC     = 3'd0;
    localparam logic [2:0] IORD_EXC    = 3'd1;
    localparam logic [2:0] IORD_ALUOUT = 3'd2;
    localparam logic [2:0] IORD_ALURES = 3'd3;

    localparam logic [1:0] EXC_BADOP = 2'd0;
    localparam logic [1:0] EXC_OVF   = 2'd1;

    localparam logic [2:0] WR_RT = 3'd0;
    localparam logic [2:0] WR_RD = 3'd1;
    localparam logic [2:0] WR_RA = 3'd2;
    localparam logic [2:0] WR_SP = 3'd3;

    localparam logic [3:0] WD_ALUOUT = 4'd0;
    localparam logic [3:0] WD_LOAD   = 4'd1;
    localparam logic [3:0] WD_PC     = 4'd2;
    localparam logic [3:0] WD_SPINIT = 4'd3;

    localparam logic [2:0] SRCA_PC   = 3'd0;
    localparam logic [2:0] SRCA_A    = 3'd1;
    localparam logic [2:0] SRCA_ZERO = 3'd2;

    localparam logic [2:0] SRCB_B    = 3'd0;
    localparam logic [2:0] SRCB_FOUR = 3'd1;
    localparam logic [2:0] SRCB_IMM  = 3'd2;
    localparam logic [2:0] SRCB_SHL2 = 3'd3;

    localparam logic [2:0] PCS_ALURES = 3'd0;
    localparam logic [2:0] PCS_ALUOUT = 3'd1;
    localparam logic [2:0] PCS_JUMP   = 3'd2;
    localparam logic [2:0] PCS_EPC    = 3'd3;

    typedef struct packed {
        logic       pc_write;
        logic       load_ab;
        logic       aluout_load;
        logic       epc_write;
        logic       mem_write;
        logic       mem_read;
        logic       ir_write;
        logic       reg_write;
        logic [2:0] iord;
        logic [1:0] exc_sel;
        logic [2:0] wr_reg;
        logic [3:0] wd_reg;
        logic [2:0] alu_src_a;
        logic [2:0] alu_src_b;
        logic [2:0] pc_source;
        logic [2:0] alu_op;
        logic       sing_ex_ctrl;
    } ctrl_t;

    function automatic logic [2:0] rtype_alu_op(input logic [5:0] fn);
        logic [2:0] op;
        op = ALU_ADD;
        if (fn == FN_SUB) op = ALU_SUB;
        if (fn == FN_AND) op = ALU_AND;
        return op;
    endfunction

endpackage

// File: rtl/control_unit.sv
// Multicycle MIPS-subset control FSM: registered state, Moore output decode with one
// Mealy term (branch PcWrite), and an exception sequence that vectors through a handler byte.
module control_unit
    import control_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_overflow,
    input  logic       alu_eq,
    output logic       PcWrite,
    output logic       Load_AB,
    output logic       ALUOut_Load,
    output logic       EPCwrite,
    output logic       MemWrite,
    output logic       MemRead,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [2:0] IorD,
    output logic [1:0] ExcSel,
    output logic [2:0] WR_REG,
    output logic [3:0] WD_REG,
    output logic [2:0] ALUSrcA,
    output logic [2:0] ALUSrcB,
    output logic [2:0] PcSource,
    output logic [2:0] ALUOp,
    output logic       SingExCtrl,
    output logic [1:0] LoadCtrl,
    output logic [1:0] StoreCtrl,
    output logic [4:0] state_dbg
);

    state_t     state_q, state_d;
    logic [1:0] excsel_q, excsel_d;
    ctrl_t      ctrl;
    ctrl_t      ctrl_o;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_RST;
            excsel_q <= EXC_BADOP;
        end else begin
            state_q  <= state_d;
            excsel_q <= excsel_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        excsel_d = excsel_q;
        case (state_q)
            S_RST: state_d = S_F0;
            S_F0:  state_d = S_F1;
            S_F1:  state_d = S_F2;
            S_F2:  state_d = S_DEC;
            S_DEC: begin
                case (opcode)
                    OP_RTYPE: begin
                        case (funct)
                            FN_ADD, FN_SUB, FN_AND: state_d = S_REX;
                            FN_JR:                  state_d = S_JR;
                            FN_RTE:                 state_d = S_RTE;
                            default: begin
                                state_d  = S_EXC0;
                                excsel_d = EXC_BADOP;
                            end
                        endcase
                    end
                    OP_ADDI, OP_ADDIU: state_d = S_IEX;
                    OP_LW, OP_SW:      state_d = S_MADR;
                    OP_BEQ, OP_BNE:    state_d = S_BR;
                    OP_J:              state_d = S_JMP;
                    OP_JAL:            state_d = S_JAL;
                    default: begin
                        state_d  = S_EXC0;
                        excsel_d = EXC_BADOP;
                    end
                endcase
            end
            // and never traps; the faulting add/sub skips its write-back entirely
            S_REX: begin
                if (alu_overflow && (funct != FN_AND)) begin
                    state_d  = S_EXC0;
                    excsel_d = EXC_OVF;
                end else begin
                    state_d = S_RWB;
                end
            end
            S_IEX: begin
                if (alu_overflow && (opcode == OP_ADDI)) begin
                    state_d  = S_EXC0;
                    excsel_d = EXC_OVF;
                end else begin
                    state_d = S_IWB;
                end
            end
            S_MADR: state_d = (opcode == OP_LW) ? S_LR0 : S_SWR;
            S_LR0:  state_d = S_LR1;
            S_LR1:  state_d = S_LWB;
            S_JAL:  state_d = S_JMP;
            S_EXC0: state_d = S_EXC1;
            S_EXC1: state_d = S_EXC2;
            S_RWB, S_IWB, S_LWB, S_SWR, S_BR, S_JMP, S_JR, S_RTE, S_EXC2:
                state_d = S_F0;
            default: state_d = S_RST;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (state_q)
            S_RST: begin
                ctrl.wr_reg    = WR_SP;
                ctrl.wd_reg    = WD_SPINIT;
                ctrl.reg_write = 1'b1;
            end
            S_F0, S_F1: begin
                ctrl.iord      = IORD_PC;
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_a = SRCA_PC;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
            end
            S_F2: begin
                ctrl.ir_write  = 1'b1;
                ctrl.pc_source = PCS_ALURES;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_a = SRCA_PC;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
            end
            S_DEC: begin
                ctrl.load_ab     = 1'b1;
                ctrl.alu_src_a   = SRCA_PC;
                ctrl.alu_src_b   = SRCB_SHL2;
                ctrl.alu_op      = ALU_ADD;
                ctrl.aluout_load = 1'b1;
            end
            S_REX: begin
                ctrl.alu_src_a   = SRCA_A;
                ctrl.alu_src_b   = SRCB_B;
                ctrl.alu_op      = rtype_alu_op(funct);
                ctrl.aluout_load = 1'b1;
            end
            S_RWB: begin
                ctrl.wr_reg    = WR_RD;
                ctrl.wd_reg    = WD_ALUOUT;
                ctrl.reg_write = 1'b1;
            end
            S_IEX, S_MADR: begin
                ctrl.alu_src_a   = SRCA_A;
                ctrl.alu_src_b   = SRCB_IMM;
                ctrl.alu_op      = ALU_ADD;
                ctrl.aluout_load = 1'b1;
            end
            S_IWB: begin
                ctrl.wr_reg    = WR_RT;
                ctrl.wd_reg    = WD_ALUOUT;
                ctrl.reg_write = 1'b1;
            end
            S_LR0, S_LR1: begin
                ctrl.iord     = IORD_ALUOUT;
                ctrl.mem_read = 1'b1;
            end
            S_LWB: begin
                ctrl.wr_reg    = WR_RT;
                ctrl.wd_reg    = WD_LOAD;
                ctrl.reg_write = 1'b1;
            end
            S_SWR: begin
                ctrl.iord      = IORD_ALUOUT;
                ctrl.mem_write = 1'b1;
            end
            // Only Mealy term: the compare result is consumed in the same cycle it is produced
            S_BR: begin
                ctrl.alu_src_a = SRCA_A;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_CMP;
                ctrl.pc_source = PCS_ALUOUT;
                ctrl.pc_write  = ((opcode == OP_BEQ) && alu_eq) ||
                                 ((opcode == OP_BNE) && !alu_eq);
            end
            S_JMP: begin
                ctrl.pc_source = PCS_JUMP;
                ctrl.pc_write  = 1'b1;
            end
            S_JAL: begin
                ctrl.wr_reg    = WR_RA;
                ctrl.wd_reg    = WD_PC;
                ctrl.reg_write = 1'b1;
            end
            S_JR: begin
                ctrl.alu_src_a = SRCA_A;
                ctrl.alu_op    = ALU_PASSA;
                ctrl.pc_source = PCS_ALURES;
                ctrl.pc_write  = 1'b1;
            end
            S_RTE: begin
                ctrl.pc_source = PCS_EPC;
                ctrl.pc_write  = 1'b1;
            end
            S_EXC0: begin
                ctrl.exc_sel   = excsel_q;
                ctrl.iord      = IORD_EXC;
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_a = SRCA_PC;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_SUB;
                ctrl.epc_write = 1'b1;
            end
            S_EXC1: begin
                ctrl.exc_sel  = excsel_q;
                ctrl.iord     = IORD_EXC;
                ctrl.mem_read = 1'b1;
            end
            S_EXC2: begin
                ctrl.exc_sel      = excsel_q;
                ctrl.sing_ex_ctrl = 1'b1;
                ctrl.alu_src_a    = SRCA_ZERO;
                ctrl.alu_src_b    = SRCB_IMM;
                ctrl.alu_op       = ALU_ADD;
                ctrl.pc_source    = PCS_ALURES;
                ctrl.pc_write     = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    // RST decodes a register write, so the bus is forced quiet while reset is held
    assign ctrl_o = reset ? '0 : ctrl;

    assign PcWrite     = ctrl_o.pc_write;
    assign Load_AB     = ctrl_o.load_ab;
    assign ALUOut_Load = ctrl_o.aluout_load;
    assign EPCwrite    = ctrl_o.epc_write;
    assign MemWrite    = ctrl_o.mem_write;
    assign MemRead     = ctrl_o.mem_read;
    assign IRWrite     = ctrl_o.ir_write;
    assign RegWrite    = ctrl_o.reg_write;
    assign IorD        = ctrl_o.iord;
    assign ExcSel      = ctrl_o.exc_sel;
    assign WR_REG      = ctrl_o.wr_reg;
    assign WD_REG      = ctrl_o.wd_reg;
    assign ALUSrcA     = ctrl_o.alu_src_a;
    assign ALUSrcB     = ctrl_o.alu_src_b;
    assign PcSource    = ctrl_o.pc_source;
    assign ALUOp       = ctrl_o.alu_op;
    assign SingExCtrl  = ctrl_o.sing_ex_ctrl;
    assign LoadCtrl    = 2'b00;
    assign StoreCtrl   = 2'b00;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: a per-instruction step-list model predicts the
// control bus every cycle; directed cases, random instructions and a mid-load reset.
module tb_control_unit;
    import control_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       alu_overflow = 1'b0;
    logic       alu_eq = 1'b0;

    logic       PcWrite, Load_AB, ALUOut_Load, EPCwrite, MemWrite, MemRead, IRWrite, RegWrite;
    logic [2:0] IorD, WR_REG, ALUSrcA, ALUSrcB, PcSource, ALUOp;
    logic [1:0] ExcSel, LoadCtrl, StoreCtrl;
    logic [3:0] WD_REG;
    logic       SingExCtrl;
    logic [4:0] state_dbg;

    control_unit dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .alu_overflow(alu_overflow), .alu_eq(alu_eq),
        .PcWrite(PcWrite), .Load_AB(Load_AB), .ALUOut_Load(ALUOut_Load), .EPCwrite(EPCwrite),
        .MemWrite(MemWrite), .MemRead(MemRead), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .IorD(IorD), .ExcSel(ExcSel), .WR_REG(WR_REG), .WD_REG(WD_REG),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PcSource(PcSource), .ALUOp(ALUOp),
        .SingExCtrl(SingExCtrl), .LoadCtrl(LoadCtrl), .StoreCtrl(StoreCtrl),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw, lab, alo, epcw, mw, mr, irw, rw;
        logic [2:0] iord;
        logic [1:0] excsel;
        logic [2:0] wr;
        logic [3:0] wd;
        logic [2:0] srca, srcb, pcs, aluop;
        logic       sext;
        logic [1:0] ldc, stc;
    } tb_ctrl_t;

    typedef struct {
        string    nm;
        tb_ctrl_t c;
        bit       chk_st;
    } exp_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        bit         ovf;
        bit         eq;
        int         len;
    } dir_t;

    exp_t     exp_q[$];
    int       checks = 0;
    int       failures = 0;
    tb_ctrl_t act;

    assign act = {PcWrite, Load_AB, ALUOut_Load, EPCwrite, MemWrite, MemRead, IRWrite, RegWrite,
                  IorD, ExcSel, WR_REG, WD_REG, ALUSrcA, ALUSrcB, PcSource, ALUOp,
                  SingExCtrl, LoadCtrl, StoreCtrl};

    task automatic push(input string nm, input tb_ctrl_t c, input bit st = 1'b0);
        exp_t e;
        e.nm = nm;
        e.c = c;
        e.chk_st = st;
        exp_q.push_back(e);
    endtask

    task automatic model_exc(input logic [1:0] s);
        tb_ctrl_t c;
        c = '0; c.excsel = s; c.iord = 3'd1; c.mr = 1'b1; c.srcb = 3'd1; c.aluop = 3'd2; c.epcw = 1'b1;
        push("EXC0", c);
        c = '0; c.excsel = s; c.iord = 3'd1; c.mr = 1'b1;
        push("EXC1", c);
        c = '0; c.excsel = s; c.sext = 1'b1; c.srca = 3'd2; c.srcb = 3'd2; c.aluop = 3'd1; c.pcw = 1'b1;
        push("EXC2", c);
    endtask

    // Appends the expected per-cycle control vectors of one instruction; n = its cycle count.
    task automatic model_instr(input logic [5:0] op, input logic [5:0] fn, input bit ovf,
                               input bit eq, output int n);
        tb_ctrl_t c;
        int start;
        start = exp_q.size();
        c = '0; c.mr = 1'b1; c.srcb = 3'd1; c.aluop = 3'd1;
        push("F0", c);
        push("F1", c);
        c.mr = 1'b0; c.irw = 1'b1; c.pcw = 1'b1;
        push("F2", c);
        c = '0; c.lab = 1'b1; c.srcb = 3'd3; c.aluop = 3'd1; c.alo = 1'b1;
        push("DEC", c);
        if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24)) begin
            c = '0; c.srca = 3'd1; c.alo = 1'b1;
            c.aluop = (fn == 6'h20) ? 3'd1 : (fn == 6'h22) ? 3'd2 : 3'd3;
            push("REX", c);
            if (ovf && fn != 6'h24) model_exc(2'd1);
            else begin
                c = '0; c.wr = 3'd1; c.rw = 1'b1;
                push("RWB", c);
            end
        end else if (op == 6'h00 && fn == 6'h08) begin
            c = '0; c.srca = 3'd1; c.pcw = 1'b1;
            push("JR", c);
        end else if (op == 6'h00 && fn == 6'h13) begin
            c = '0; c.pcs = 3'd3; c.pcw = 1'b1;
            push("RTE", c);
        end else if (op == 6'h08 || op == 6'h09) begin
            c = '0; c.srca = 3'd1; c.srcb = 3'd2; c.aluop = 3'd1; c.alo = 1'b1;
            push("IEX", c);
            if (ovf && op == 6'h08) model_exc(2'd1);
            else begin
                c = '0; c.rw = 1'b1;
                push("IWB", c);
            end
        end else if (op == 6'h23 || op == 6'h2B) begin
            c = '0; c.srca = 3'd1; c.srcb = 3'd2; c.aluop = 3'd1; c.alo = 1'b1;
            push("MADR", c);
            if (op == 6'h23) begin
                c = '0; c.iord = 3'd2; c.mr = 1'b1;
                push("LR0", c);
                push("LR1", c);
                c = '0; c.wd = 4'd1; c.rw = 1'b1;
                push("LWB", c);
            end else begin
                c = '0; c.iord = 3'd2; c.mw = 1'b1;
                push("SWR", c);
            end
        end else if (op == 6'h04 || op == 6'h05) begin
            c = '0; c.srca = 3'd1; c.aluop = 3'd7; c.pcs = 3'd1;
            c.pcw = (op == 6'h04) ? eq : !eq;
            push("BR", c);
        end else if (op == 6'h02 || op == 6'h03) begin
            if (op == 6'h03) begin
                c = '0; c.wr = 3'd2; c.wd = 4'd2; c.rw = 1'b1;
                push("JAL", c);
            end
            c = '0; c.pcs = 3'd2; c.pcw = 1'b1;
            push("JMP", c);
        end else begin
            model_exc(2'd0);
        end
        n = exp_q.size() - start;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (act !== e.c) begin
                failures++;
                $display("FAIL step=%s t=%0t ctrl act=%h exp=%h", e.nm, $time, act, e.c);
            end
            if (e.chk_st) begin
                checks++;
                if (state_dbg !== 5'(S_RST)) begin
                    failures++;
                    $display("FAIL step=%s state_dbg act=%0d exp=%0d", e.nm, state_dbg, 5'(S_RST));
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        tb_ctrl_t c;
        reset = 1'b0;
        c = '0; c.wr = 3'd3; c.wd = 4'd3; c.rw = 1'b1;
        push("RST", c, 1'b1);
        #1;
        checks++;
        if (RegWrite !== 1'b1 || WR_REG !== 3'd3 || WD_REG !== 4'd3) begin
            failures++;
            $display("FAIL rst_literal act rw=%b wr=%0d wd=%0d exp rw=1 wr=3 wd=3", RegWrite, WR_REG, WD_REG);
        end
        cycles(1);
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit ovf,
                             input bit eq, output int n);
        opcode = op;
        funct = fn;
        alu_overflow = ovf;
        alu_eq = eq;
        model_instr(op, fn, ovf, eq, n);
        $display("instr op=%h fn=%h ovf=%0d eq=%0d cycles=%0d", op, fn, ovf, eq, n);
        cycles(n);
    endtask

    function automatic bit legal_op(input logic [5:0] op);
        return op == 6'h00 || op == 6'h02 || op == 6'h03 || op == 6'h04 || op == 6'h05 ||
               op == 6'h08 || op == 6'h09 || op == 6'h23 || op == 6'h2B;
    endfunction

    initial begin
        dir_t dir[$];
        logic [5:0] ops[9];
        logic [5:0] fns[5];
        logic [5:0] op, fn;
        int n;
        tb_ctrl_t zero;

        ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h23, 6'h2B};
        fns = '{6'h20, 6'h22, 6'h24, 6'h08, 6'h13};
        zero = '0;
        dir = '{
            '{6'h00, 6'h20, 1'b0, 1'b0, 6}, '{6'h00, 6'h20, 1'b1, 1'b0, 8},
            '{6'h04, 6'h00, 1'b0, 1'b1, 5}, '{6'h05, 6'h00, 1'b0, 1'b1, 5},
            '{6'h3F, 6'h00, 1'b0, 1'b0, 7}, '{6'h03, 6'h00, 1'b0, 1'b0, 6},
            '{6'h23, 6'h00, 1'b0, 1'b0, 8}, '{6'h2B, 6'h00, 1'b0, 1'b0, 6},
            '{6'h02, 6'h00, 1'b0, 1'b0, 5}, '{6'h00, 6'h08, 1'b0, 1'b0, 5},
            '{6'h00, 6'h13, 1'b0, 1'b0, 5}, '{6'h08, 6'h00, 1'b1, 1'b0, 8},
            '{6'h09, 6'h00, 1'b1, 1'b0, 6}, '{6'h00, 6'h22, 1'b1, 1'b0, 8},
            '{6'h00, 6'h24, 1'b1, 1'b0, 6}, '{6'h05, 6'h00, 1'b0, 1'b0, 5},
            '{6'h04, 6'h00, 1'b0, 1'b0, 5}
        };

        cycles(2);
        checks++;
        if (act !== zero || state_dbg !== 5'(S_RST)) begin
            failures++;
            $display("FAIL reset_hold act=%h state=%0d exp=0 state=%0d", act, state_dbg, 5'(S_RST));
        end
        release_reset();

        foreach (dir[i]) begin
            run_instr(dir[i].op, dir[i].fn, dir[i].ovf, dir[i].eq, n);
            checks++;
            if (n != dir[i].len) begin
                failures++;
                $display("FAIL cycle_count op=%h fn=%h act=%0d exp=%0d", dir[i].op, dir[i].fn, n, dir[i].len);
            end
        end

        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                op = 6'($urandom_range(0, 63));
                while (legal_op(op)) op = 6'($urandom_range(0, 63));
            end else begin
                op = ops[$urandom_range(0, 8)];
            end
            fn = fns[$urandom_range(0, 4)];
            run_instr(op, fn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), n);
        end

        // Abort a load while its second memory-read cycle is on the bus.
        opcode = 6'h23; funct = 6'h00; alu_overflow = 1'b0; alu_eq = 1'b0;
        model_instr(6'h23, 6'h00, 1'b0, 1'b0, n);
        cycles(6);
        reset = 1'b1;
        #1;
        checks++;
        if (act !== zero || state_dbg !== 5'(S_RST)) begin
            failures++;
            $display("FAIL midreset_zero act=%h state=%0d exp=0 state=%0d", act, state_dbg, 5'(S_RST));
        end
        exp_q.delete();
        push("RST_HELD", zero, 1'b1);
        $display("reset asserted during LR1");
        cycles(1);
        release_reset();

        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 8)];
            fn = fns[$urandom_range(0, 4)];
            run_instr(op, fn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), n);
        end

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain act=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
